axi4_burst_mem_slave: RTL and testbench

- Next-generation AXI4 memory-mapped slave. Word-addressed on-chip RAM sits behind independent write (AW/W/B) and read (AR/R) channels.
- Generalised over the current slave: parametrised data width and depth, FIXED/INCR/WRAP bursts, WSTRB byte enables, and per-burst error responses (range, size, 4 KB, WRAP length).
- Sits directly on the TB/DUT AXI interface bundle; it is the DUT of the verification environment.

---
 rtl/axi4_burst_mem_slave.sv | 187 ++++++++++++++++++
 tb/tb_axi4_burst_mem_slave.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_mem_slave.sv
// axi4_burst_mem_slave: AXI4 burst RAM slave with FIXED/INCR/WRAP bursts, WSTRB and SLVERR checks.
// Defining AXI_SLV_ERR_COUNT_EN adds the saturating ERR_CNT output.
module axi4_burst_mem_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                    ACLK,
   input  logic                    ARESTN,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [7:0]              AWLEN,
   input  logic [2:0]              AWSIZE,
   input  logic [1:0]              AWBURST,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WLAST,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic [2:0]              ARSIZE,
   input  logic [1:0]              ARBURST,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic                    RVALID,
   input  logic                    RREADY
`ifdef AXI_SLV_ERR_COUNT_EN
   ,
   output logic [15:0]             ERR_CNT
`endif
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int LB = $clog2(NB);
   localparam int IW = $clog2(MEM_DEPTH);

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   function automatic logic burst_err(addr_t a, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
      logic [31:0] span;
      span = (32'(len) + 32'd1) << size;
      return (32'(size) > LB) || (burst == 2'b11) ||
             (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
             (burst == 2'b01 && (32'(a) & 32'hFFF) + span > 32'h1000);
   endfunction

   // WRAP spans are powers of two, so reaching the top of the window means the
   // incremented address became span-aligned; stepping back one span lands on the boundary.
   function automatic addr_t next_addr(addr_t a, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
      addr_t span, nxt;
      span = addr_t'((32'(len) + 32'd1) << size);
      nxt  = a + (addr_t'(1) << size);
      if (burst == 2'b00) return a;
      return (burst == 2'b10 && (nxt & (span - addr_t'(1))) == '0) ? nxt - span : nxt;
   endfunction

   function automatic logic in_range(addr_t a);
      return 32'(a >> LB) < MEM_DEPTH;
   endfunction

   function automatic logic [IW-1:0] idx(addr_t a);
      return IW'(a >> LB);
   endfunction

   w_state_t w_st, w_nxt;
   r_state_t r_st, r_nxt;
   addr_t w_addr, r_addr, fetch;
   logic [7:0] w_len, w_cnt, r_len, r_cnt;
   logic [2:0] w_size, r_size;
   logic [1:0] w_burst, r_burst;
   logic w_berr, w_err, r_berr, fetch_bad, aw_hs, w_hs, ar_hs, r_hs;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign ar_hs = ARVALID && ARREADY;
   assign r_hs  = RVALID && RREADY;
   assign fetch = ar_hs ? ARADDR : next_addr(r_addr, r_len, r_size, r_burst);
   assign fetch_bad = (ar_hs ? burst_err(ARADDR, ARLEN, ARSIZE, ARBURST) : r_berr) || !in_range(fetch);

   always_comb begin
      w_nxt = w_st;
      if (w_st == W_IDLE && AWVALID) w_nxt = W_DATA;
      if (w_st == W_DATA && WVALID && w_cnt == w_len) w_nxt = W_RESP;
      if (w_st == W_RESP && BREADY) w_nxt = W_IDLE;
      r_nxt = r_st;
      if (r_st == R_IDLE && ARVALID) r_nxt = R_DATA;
      if (r_st == R_DATA && RREADY && RLAST) r_nxt = R_IDLE;
      AWREADY = w_st == W_IDLE;
      WREADY  = w_st == W_DATA;
      BVALID  = w_st == W_RESP;
      BRESP   = {BVALID && w_err, 1'b0};
      ARREADY = r_st == R_IDLE;
      RVALID  = r_st == R_DATA;
   end

   always_ff @(posedge ACLK) begin
      if (!ARESTN) begin
         w_st <= W_IDLE;
         r_st <= R_IDLE;
      end else begin
         w_st <= w_nxt;
         r_st <= r_nxt;
      end
   end

   // WLAST is only a cross-check: the beat count alone ends the burst.
   always_ff @(posedge ACLK) begin
      if (aw_hs) begin
         w_addr  <= AWADDR;
         w_len   <= AWLEN;
         w_size  <= AWSIZE;
         w_burst <= AWBURST;
         w_cnt   <= '0;
         w_berr  <= burst_err(AWADDR, AWLEN, AWSIZE, AWBURST);
         w_err   <= burst_err(AWADDR, AWLEN, AWSIZE, AWBURST);
      end else if (w_hs) begin
         w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
         w_cnt  <= w_cnt + 8'd1;
         w_err  <= w_err || !in_range(w_addr) || (WLAST != (w_cnt == w_len));
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESTN && w_hs && !w_berr && in_range(w_addr))
         for (int b = 0; b < NB; b++)
            if (WSTRB[b]) mem[idx(w_addr)][b*8 +: 8] <= WDATA[b*8 +: 8];
   end

   always_ff @(posedge ACLK) begin
      if (ar_hs) begin
         r_addr  <= ARADDR;
         r_len   <= ARLEN;
         r_size  <= ARSIZE;
         r_burst <= ARBURST;
         r_cnt   <= '0;
         r_berr  <= burst_err(ARADDR, ARLEN, ARSIZE, ARBURST);
      end else if (r_hs) begin
         r_addr <= fetch;
         r_cnt  <= r_cnt + 8'd1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESTN) begin
         RDATA <= '0;
         RRESP <= 2'b00;
         RLAST <= 1'b0;
      end else if (ar_hs || (r_hs && !RLAST)) begin
         RDATA <= fetch_bad ? '0 : mem[idx(fetch)];
         RRESP <= fetch_bad ? 2'b10 : 2'b00;
         RLAST <= ar_hs ? (ARLEN == 8'd0) : (r_cnt + 8'd1 == r_len);
      end else if (r_hs) begin
         RDATA <= '0;
         RRESP <= 2'b00;
         RLAST <= 1'b0;
      end
   end

`ifdef AXI_SLV_ERR_COUNT_EN
   logic r_any, b_hs;
   logic [16:0] err_sum;
   assign b_hs    = BVALID && BREADY;
   assign err_sum = {1'b0, ERR_CNT} + 17'(b_hs && w_err) + 17'(r_hs && RLAST && (r_any || RRESP[1]));

   always_ff @(posedge ACLK) begin
      if (ar_hs) r_any <= 1'b0;
      else if (r_hs) r_any <= r_any || RRESP[1];
   end

   always_ff @(posedge ACLK) begin
      if (!ARESTN) ERR_CNT <= '0;
      else ERR_CNT <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end
`endif

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// tb_axi4_burst_mem_slave: directed bursts checked against a byte-level memory model and
// per-beat expectation queues; a negedge monitor compares every valid B and R cycle.
module tb_axi4_burst_mem_slave;

   logic        ACLK = 0, ARESTN = 0;
   logic [15:0] AWADDR = 0, ARADDR = 0;
   logic [7:0]  AWLEN = 0, ARLEN = 0;
   logic [2:0]  AWSIZE = 0, ARSIZE = 0;
   logic [1:0]  AWBURST = 0, ARBURST = 0, BRESP, RRESP;
   logic        AWVALID = 0, AWREADY, WLAST = 0, WVALID = 0, WREADY, BVALID, BREADY = 0;
   logic [31:0] WDATA = 0, RDATA;
   logic [3:0]  WSTRB = 0;
   logic        ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 0;
`ifdef AXI_SLV_ERR_COUNT_EN
   logic [15:0] ERR_CNT;
`endif

   always #5 ACLK = ~ACLK;

   axi4_burst_mem_slave dut (
      .ACLK(ACLK), .ARESTN(ARESTN),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
`ifdef AXI_SLV_ERR_COUNT_EN
      , .ERR_CNT(ERR_CNT)
`endif
   );

   typedef struct {logic [31:0] d; logic [1:0] r; logic l;} beat_t;

   int vecs = 0, errs = 0, ecnt = 0;
   logic [31:0] mdl [1024];
   logic [31:0] wd [16];
   logic [31:0] got [16];
   beat_t rq [$];
   logic [1:0] bq [$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int baddr(int a, int len, int size, int burst, int i);
      int tot = (len + 1) << size;
      int bnd = (a / tot) * tot;
      if (burst == 0) return a;
      if (burst == 2) return bnd + (a - bnd + (i << size)) % tot;
      return (a + (i << size)) & 'hFFFF;
   endfunction

   function automatic bit berr(int a, int len, int size, int burst);
      int bytes = (len + 1) << size;
      return size > 2 || burst == 3 ||
             (burst == 2 && len != 1 && len != 3 && len != 7 && len != 15) ||
             (burst == 1 && a / 4096 != (a + bytes - 1) / 4096);
   endfunction

   // Monitor: every valid B/R cycle must match the head of the expectation queue.
   always @(negedge ACLK) begin
      if (ARESTN && BVALID) begin
         if (bq.size() == 0) chk("b_unexpected", BVALID, 0);
         else begin
            chk("bresp", BRESP, bq[0]);
            if (BREADY) void'(bq.pop_front());
         end
      end
      if (ARESTN && RVALID) begin
         if (rq.size() == 0) chk("r_unexpected", RVALID, 0);
         else begin
            chk("rdata", RDATA, rq[0].d);
            chk("rresp", RRESP, rq[0].r);
            chk("rlast", RLAST, rq[0].l);
            if (RREADY) void'(rq.pop_front());
         end
      end
   end

   task automatic wr(input int a, input int len, input int size, input int burst,
                     input logic [3:0] strb, input int wl_at);
      bit e = berr(a, len, size, burst) || wl_at != len;
      int n = 0, t = 0;
      for (int i = 0; i <= len; i++) if (baddr(a, len, size, burst, i) / 4 >= 1024) e = 1;
      bq.push_back(e ? 2'b10 : 2'b00);
      if (e) ecnt++;
      @(posedge ACLK); #1;
      AWADDR = a[15:0]; AWLEN = len[7:0]; AWSIZE = size[2:0]; AWBURST = burst[1:0]; AWVALID = 1;
      @(negedge ACLK);
      while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
      chk("aw_wait", t < 50, 1);
      @(posedge ACLK); #1;
      AWVALID = 0;
      t = 0;
      while (n <= len && t < 200) begin
         WVALID = 1; WDATA = wd[n]; WSTRB = strb; WLAST = (n == wl_at);
         @(negedge ACLK);
         if (WREADY) begin
            int w = baddr(a, len, size, burst, n) / 4;
            if (!berr(a, len, size, burst) && w < 1024)
               for (int b = 0; b < 4; b++) if (strb[b]) mdl[w][b*8 +: 8] = wd[n][b*8 +: 8];
            n++;
         end
         @(posedge ACLK); #1;
         t++;
      end
      WVALID = 0; WLAST = 0;
      chk("w_beats", n, len + 1);
      BREADY = 1; t = 0;
      @(negedge ACLK);
      while (!BVALID && t < 50) begin @(negedge ACLK); t++; end
      chk("b_wait", t < 50, 1);
      @(posedge ACLK); #1;
      BREADY = 0;
      chk("awready_after_b", AWREADY, 1);
   endtask

   task automatic push_rd(input int a, input int len, input int size, input int burst);
      bit any = 0;
      for (int i = 0; i <= len; i++) begin
         beat_t x;
         int w = baddr(a, len, size, burst, i) / 4;
         bit bad = berr(a, len, size, burst) || w >= 1024;
         x.d = 0;
         if (!bad) x.d = mdl[w];
         x.r = bad ? 2'b10 : 2'b00;
         x.l = (i == len);
         rq.push_back(x);
         any |= bad;
      end
      if (any) ecnt++;
   endtask

   task automatic send_ar(input int a, input int len, input int size, input int burst);
      int t = 0;
      @(posedge ACLK); #1;
      ARADDR = a[15:0]; ARLEN = len[7:0]; ARSIZE = size[2:0]; ARBURST = burst[1:0]; ARVALID = 1;
      @(negedge ACLK);
      while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
      chk("ar_wait", t < 50, 1);
      @(posedge ACLK); #1;
      ARVALID = 0;
   endtask

   task automatic rd(input int a, input int len, input int size, input int burst, input bit stall);
      int n = 0, t = 0;
      push_rd(a, len, size, burst);
      send_ar(a, len, size, burst);
      while (n <= len && t < 300) begin
         RREADY = stall ? (t % 3 == 0) : 1'b1;
         @(negedge ACLK);
         if (RVALID && RREADY) begin got[n] = RDATA; n++; end
         @(posedge ACLK); #1;
         t++;
      end
      RREADY = 0;
      chk("r_beats", n, len + 1);
      chk("rvalid_after_last", RVALID, 0);
      chk("arready_after_last", ARREADY, 1);
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_awready"}, AWREADY, 1);
      chk({tag, "_arready"}, ARREADY, 1);
      chk({tag, "_wready"}, WREADY, 0);
      chk({tag, "_bvalid"}, BVALID, 0);
      chk({tag, "_rvalid"}, RVALID, 0);
      chk({tag, "_rlast"}, RLAST, 0);
      chk({tag, "_bresp"}, BRESP, 0);
      chk({tag, "_rresp"}, RRESP, 0);
      chk({tag, "_rdata"}, RDATA, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge ACLK);
      #1;
      rst_chk("reset");
      ARESTN = 1;
      chk("model_wrap2", baddr('h38, 3, 2, 2, 2), 'h30);
      chk("model_wrap3", baddr('h38, 3, 2, 2, 3), 'h34);
      chk("model_4k_cross", berr('hFF8, 3, 2, 1), 1);
      chk("model_4k_fit", berr('hFF8, 1, 2, 1), 0);

      for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
      wr('h10, 3, 2, 1, 4'hF, 3);
      rd('h10, 3, 2, 1, 0);
      for (int i = 0; i < 4; i++) chk("incr_readback", got[i], 32'hA0 + i);

      for (int i = 0; i < 4; i++) wd[i] = i + 1;
      wr('h38, 3, 2, 2, 4'hF, 3);
      rd('h30, 3, 2, 1, 0);
      chk("wrap_w0", got[0], 3);
      chk("wrap_w1", got[1], 4);
      chk("wrap_w2", got[2], 1);
      chk("wrap_w3", got[3], 2);

      wd[0] = 0;
      wr('h40, 0, 2, 1, 4'hF, 0);
      wd[0] = 32'hAABBCCDD;
      wr('h40, 0, 2, 1, 4'b0101, 0);
      rd('h40, 0, 2, 1, 0);
      chk("wstrb_merge", got[0], 32'h00BB00DD);

      wd[0] = 32'h55; wd[1] = 32'h66;
      wr('hFF8, 1, 2, 1, 4'hF, 1);
      for (int i = 0; i < 4; i++) wd[i] = 32'hDEAD0000 + i;
      wr('hFF8, 3, 2, 1, 4'hF, 3);
      rd('hFF8, 1, 2, 1, 0);
      chk("4k_unchanged0", got[0], 32'h55);
      chk("4k_unchanged1", got[1], 32'h66);
      rd('h100, 2, 3, 1, 0);
      for (int i = 0; i < 3; i++) chk("size_err_zero", got[i], 0);

      for (int i = 0; i < 3; i++) wd[i] = 7 + i;
      wr('h80, 2, 2, 0, 4'hF, 2);
      rd('h80, 1, 2, 0, 0);
      chk("fixed0", got[0], 9);
      chk("fixed1", got[1], 9);

      wd[0] = 32'h11; wd[1] = 32'h12;
      wr('h90, 1, 2, 1, 4'hF, 0);
      rd('h90, 1, 2, 1, 0);
      chk("early_wlast0", got[0], 32'h11);
      chk("early_wlast1", got[1], 32'h12);

      rd('h1000, 1, 2, 1, 0);
      chk("range_zero", got[0], 0);

      for (int i = 0; i < 4; i++) wd[i] = 5 + i;
      wr('h20, 3, 2, 1, 4'hF, 3);
      for (int i = 0; i < 4; i++) wd[i] = 32'hC0DE0000 + i;
      fork
         rd('h10, 7, 2, 1, 1);
         wr('h200, 3, 2, 1, 4'hF, 3);
      join
      for (int i = 0; i < 4; i++) chk("stall_lo", got[i], 32'hA0 + i);
      for (int i = 4; i < 8; i++) chk("stall_hi", got[i], 1 + i);
      rd('h200, 3, 2, 1, 0);
      for (int i = 0; i < 4; i++) chk("concurrent_wr", got[i], 32'hC0DE0000 + i);
`ifdef AXI_SLV_ERR_COUNT_EN
      chk("err_cnt_run", ERR_CNT, ecnt);
`endif

      push_rd('h10, 7, 2, 1);
      send_ar('h10, 7, 2, 1);
      RREADY = 1;
      repeat (2) begin @(negedge ACLK); @(posedge ACLK); #1; end
      RREADY = 0;
      ARESTN = 0;
      @(posedge ACLK); #1;
      rq.delete();
      rst_chk("midread_reset");
`ifdef AXI_SLV_ERR_COUNT_EN
      chk("err_cnt_reset", ERR_CNT, 0);
`endif
      ecnt = 0;
      ARESTN = 1;
      rd('h10, 3, 2, 1, 0);
      chk("after_reset0", got[0], 32'hA0);
      chk("after_reset3", got[3], 32'hA3);
      wr('h2000, 0, 2, 1, 4'hF, 0);
      rd('h100, 1, 3, 1, 0);
`ifdef AXI_SLV_ERR_COUNT_EN
      chk("err_cnt_two", ERR_CNT, 2);
`endif

      repeat (3) @(posedge ACLK);
      chk("b_queue_drained", bq.size(), 0);
      chk("r_queue_drained", rq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
